// File: rtl/ram_pkg.sv
// Shared types and default sizing for the RAM burst port controller.
package ram_pkg;

  // Controller FSM states: idle, streaming a write burst, or issuing a read burst.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } ctrl_state_e;

  localparam int DEF_ADDR      = 10;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_LEN_W     = 8;
  localparam int DEF_RSP_DEPTH = 4;

endpackage

// File: rtl/ram_burst_port_ctrl_if.sv
// Engine-side and RAM-side signals of one RAM burst port controller.
// master = engine plus RAM macro (the environment), slave = the controller.
interface ram_burst_port_ctrl_if #(
  parameter int ADDR  = ram_pkg::DEF_ADDR,
  parameter int WIDTH = ram_pkg::DEF_WIDTH,
  parameter int LEN_W = ram_pkg::DEF_LEN_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [ADDR-1:0]  cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wd_valid;
  logic             wd_ready;
  logic [WIDTH-1:0] wd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_last;
  logic             busy;
  logic             ram_en;
  logic             ram_we;
  logic [ADDR-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_dout;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready, ram_dout,
    input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last, busy,
           ram_en, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready, ram_dout,
    output cmd_ready, wd_ready, rd_valid, rd_data, rd_last, busy,
           ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_rsp_fifo.sv
// Read response FIFO with empty-bypass: a push into an empty FIFO is visible
// at the output in the same cycle, and is only stored if not popped at once.
module ram_rsp_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          store;
  logic          take;

  assign empty     = (count == '0);
  assign out_valid = !empty || push;
  assign out_data  = empty ? push_data : mem[rd_ptr];
  // A bypassed beat consumed in its arrival cycle never enters storage.
  assign store     = push && !(empty && pop);
  assign take      = pop && !empty;

  // Pointer and occupancy bookkeeping; push and pop together keep count steady.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (take)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(store) - CW'(take);
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: the array is not reset; emptiness is tracked by count, so stale
    // contents are never observed and the array can map onto plain RAM cells.
    if (store) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_burst_port_ctrl.sv
// Burst controller for one port of a dual-port RAM: turns burst commands and a
// write-data stream into per-beat RAM strobes, and returns read data through a
// credit-managed response FIFO so backpressure never loses a 1-cycle-latency beat.
module ram_burst_port_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR      = DEF_ADDR,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_burst_port_ctrl_if.slave  bus
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  ctrl_state_e      state;
  logic [ADDR-1:0]  cur_addr;
  logic [LEN_W-1:0] remaining;
  logic             inflight;
  logic             inflight_last;

  logic [CW-1:0]    fifo_count;
  logic [CW:0]      used;
  logic             credit_ok;
  logic             cmd_fire;
  logic             wr_beat;
  logic             rd_issue;
  logic             last_beat;
  logic             fifo_valid;
  logic [WIDTH:0]   fifo_out;

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.wd_ready  = (state == WRITE) && !rst;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign last_beat     = (remaining == '0);

  // Queued plus in-flight beats must leave room for the beat about to be issued.
  assign used      = {1'b0, fifo_count} + (CW + 1)'(inflight);
  assign credit_ok = used < (CW + 1)'(RSP_DEPTH);

  // Decide whether this cycle carries a write beat or a read issue.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    wr_beat  = 1'b0;
    rd_issue = 1'b0;
    if (!rst) begin
      unique case (state)
        WRITE:   wr_beat  = bus.wd_valid;
        READ:    rd_issue = credit_ok;
        default: ;
      endcase
    end
  end

  assign bus.ram_en   = wr_beat || rd_issue;
  assign bus.ram_we   = wr_beat;
  assign bus.ram_addr = cur_addr;
  assign bus.ram_din  = bus.wd_data;

  // Burst FSM with address/beat counters and the read in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && last_beat;
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            cur_addr  <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            state     <= bus.cmd_we ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          if (wr_beat || rd_issue) begin
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ram_rsp_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, bus.ram_dout}),
    .pop       (bus.rd_valid && bus.rd_ready),
    .out_valid (fifo_valid),
    .out_data  (fifo_out),
    .count     (fifo_count)
  );

  assign bus.rd_valid = fifo_valid;
  assign bus.rd_data  = fifo_out[WIDTH-1:0];
  assign bus.rd_last  = fifo_valid && fifo_out[WIDTH];
  assign bus.busy     = (state != IDLE) || inflight || (fifo_count != '0);

endmodule

// File: tb/tb_ram_burst_port_ctrl.sv
// Directed bench for ram_burst_port_ctrl with a behavioural 1-cycle-latency RAM.
module tb_ram_burst_port_ctrl;
  localparam int ADDR  = 10;
  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_burst_port_ctrl_if #(.ADDR(ADDR), .WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  ram_burst_port_ctrl #(
    .ADDR(ADDR), .WIDTH(WIDTH), .LEN_W(LEN_W), .RSP_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int acc_cyc    = 0;
  int rd_iss     = 0;
  int bad_en     = 0;

  typedef struct {
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t              wr_q[$];
  logic [WIDTH:0]   rd_q[$];
  int               rd_cyc[$];
  logic [WIDTH-1:0] mem [2**ADDR];

  // Behavioural RAM port plus cycle counter.
  always @(posedge clk) begin
    cyc++;
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout      <= mem[bus.ram_addr];
    end
  end

  // Transfer monitor, sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (bus.ram_en && bus.ram_we) begin
      wr_q.push_back('{bus.ram_addr, bus.ram_din});
      if (!bus.wd_valid) bad_en++;
    end
    if (bus.ram_en && !bus.ram_we) rd_iss++;
    if (bus.rd_valid && bus.rd_ready) begin
      rd_q.push_back({bus.rd_last, bus.rd_data});
      rd_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
    rd_cyc.delete();
    rd_iss = 0;
    bad_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic we, input logic [ADDR-1:0] a, input logic [LEN_W-1:0] l);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    #1;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (!bus.cmd_ready) begin
      mismatched++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    acc_cyc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [WIDTH-1:0] d0, input bit toggle);
    int sent = 0;
    int k    = 0;
    while (sent < n && k < 100) begin
      @(negedge clk);
      bus.wd_valid = toggle ? (k % 2 == 0) : 1'b1;
      bus.wd_data  = d0 + WIDTH'(sent);
      #1;
      if (bus.wd_valid && bus.wd_ready) sent++;
      k++;
    end
    @(negedge clk);
    bus.wd_valid = 1'b0;
    compared++;
    if (sent != n) begin
      mismatched++;
      $display("FAIL write_beats_timeout: accepted=%0d required %0d", sent, n);
    end
  endtask

  task automatic wait_reads(input int n);
    int k = 0;
    while (rd_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wd_valid  = 1'b0; bus.wd_data = '0; bus.rd_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (bus.cmd_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_cmd_ready_in_rst: got %b required 0", bus.cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if ({bus.cmd_ready, bus.wd_ready, bus.rd_valid, bus.rd_last, bus.busy, bus.ram_en, bus.ram_we}
        !== 7'b1000000) begin
      mismatched++;
      $display("FAIL reset_outputs: {cmd_rdy,wd_rdy,rd_v,rd_last,busy,en,we}=%b required 1000000",
               {bus.cmd_ready, bus.wd_ready, bus.rd_valid, bus.rd_last, bus.busy, bus.ram_en, bus.ram_we});
    end
  endtask

  task automatic test_write_basic();
    clear_logs();
    send_cmd(1'b1, 10'h010, 8'd3);
    write_beats(4, 16'h00A0, 1'b0);
    #1;
    compared++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL write_idle_after: cmd_ready=%b busy=%b required 1 0", bus.cmd_ready, bus.busy);
    end
    compared++;
    if (wr_q.size() != 4) begin
      mismatched++;
      $display("FAIL write_count: got %0d required 4", wr_q.size());
    end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      compared++;
      if (wr_q[i].addr !== 10'h010 + ADDR'(i) || wr_q[i].data !== 16'h00A0 + WIDTH'(i)) begin
        mismatched++;
        $display("FAIL write_beat%0d: addr=%h data=%h required %h %h", i, wr_q[i].addr,
                 wr_q[i].data, 10'h010 + ADDR'(i), 16'h00A0 + WIDTH'(i));
      end
    end
  endtask

  task automatic test_read_basic();
    logic [WIDTH:0] e;
    clear_logs();
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 8'd3);
    wait_reads(4);
    idle(4);
    compared++;
    if (rd_q.size() != 4) begin
      mismatched++;
      $display("FAIL read_count: got %0d required 4", rd_q.size());
    end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      e = {(i == 3), 16'h00A0 + WIDTH'(i)};
      compared++;
      if (rd_q[i] !== e || rd_cyc[i] != acc_cyc + 2 + i) begin
        mismatched++;
        $display("FAIL read_beat%0d: {last,data}=%h cycle=%0d required %h cycle %0d", i,
                 rd_q[i], rd_cyc[i], e, acc_cyc + 2 + i);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] e;
    send_cmd(1'b1, 10'h100, 8'd7);
    write_beats(8, 16'h00B0, 1'b0);
    clear_logs();
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 10'h100, 8'd7);
    idle(20);
    #3;
    compared++;
    if (rd_iss != 4 || bus.ram_en !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_credit_stall: issued=%0d ram_en=%b required 4 0", rd_iss, bus.ram_en);
    end
    compared++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h00B0 || bus.busy !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_head_held: rd_valid=%b rd_data=%h busy=%b required 1 00b0 1",
               bus.rd_valid, bus.rd_data, bus.busy);
    end
    @(negedge clk);
    bus.rd_ready = 1'b1;
    wait_reads(8);
    idle(6);
    compared++;
    if (rd_q.size() != 8 || rd_iss != 8) begin
      mismatched++;
      $display("FAIL bp_totals: popped=%0d issued=%0d required 8 8", rd_q.size(), rd_iss);
    end
    for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
      e = {(i == 7), 16'h00B0 + WIDTH'(i)};
      compared++;
      if (rd_q[i] !== e) begin
        mismatched++;
        $display("FAIL bp_beat%0d: {last,data}=%h required %h", i, rd_q[i], e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [ADDR-1:0] ea;
    logic [WIDTH:0]  e;
    clear_logs();
    send_cmd(1'b1, 10'h3FE, 8'd3);
    write_beats(4, 16'h00C0, 1'b0);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      ea = 10'h3FE + ADDR'(i);
      compared++;
      if (wr_q[i].addr !== ea) begin
        mismatched++;
        $display("FAIL wrap_addr%0d: got %h required %h", i, wr_q[i].addr, ea);
      end
    end
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 10'h3FE, 8'd3);
    wait_reads(4);
    idle(4);
    compared++;
    if (wr_q.size() != 4 || rd_q.size() != 4) begin
      mismatched++;
      $display("FAIL wrap_counts: writes=%0d reads=%0d required 4 4", wr_q.size(), rd_q.size());
    end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      e = {(i == 3), 16'h00C0 + WIDTH'(i)};
      compared++;
      if (rd_q[i] !== e) begin
        mismatched++;
        $display("FAIL wrap_read%0d: {last,data}=%h required %h", i, rd_q[i], e);
      end
    end
  endtask

  task automatic test_gapped_write();
    clear_logs();
    send_cmd(1'b1, 10'h200, 8'd3);
    write_beats(4, 16'h0050, 1'b1);
    idle(2);
    compared++;
    if (wr_q.size() != 4 || bad_en != 0) begin
      mismatched++;
      $display("FAIL gap_write: writes=%0d en_without_valid=%0d required 4 0", wr_q.size(), bad_en);
    end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      compared++;
      if (wr_q[i].addr !== 10'h200 + ADDR'(i) || wr_q[i].data !== 16'h0050 + WIDTH'(i)) begin
        mismatched++;
        $display("FAIL gap_beat%0d: addr=%h data=%h required %h %h", i, wr_q[i].addr,
                 wr_q[i].data, 10'h200 + ADDR'(i), 16'h0050 + WIDTH'(i));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    send_cmd(1'b1, 10'h300, 8'd7);
    write_beats(8, 16'h00D0, 1'b0);
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 10'h300, 8'd7);
    idle(3);
    #1;
    compared++;
    if (bus.rd_valid !== 1'b1 || bus.busy !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_pre: rd_valid=%b busy=%b required 1 1", bus.rd_valid, bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ram_en !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_post: rd_valid=%b busy=%b ram_en=%b cmd_ready=%b required 0 0 0 1",
               bus.rd_valid, bus.busy, bus.ram_en, bus.cmd_ready);
    end
    send_cmd(1'b1, 10'h310, 8'd1);
    write_beats(2, 16'h00E0, 1'b0);
    clear_logs();
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 10'h310, 8'd1);
    wait_reads(2);
    idle(5);
    compared++;
    if (rd_q.size() != 2) begin
      mismatched++;
      $display("FAIL rstmid_fresh_count: got %0d required 2", rd_q.size());
    end
    for (int i = 0; i < 2 && i < rd_q.size(); i++) begin
      compared++;
      if (rd_q[i] !== {(i == 1), 16'h00E0 + WIDTH'(i)}) begin
        mismatched++;
        $display("FAIL rstmid_fresh%0d: {last,data}=%h required %h", i, rd_q[i],
                 {(i == 1), 16'h00E0 + WIDTH'(i)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_backpressure();
    test_wrap();
    test_gapped_write();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
